irq_controller: RTL and testbench
=================================

# irq_controller

Memory-mapped interrupt controller sitting directly upstream of the CPU core. It synchronises four raw peripheral event lines and latches them as pending bits. It masks them and drives the core's `interrupt_0..3` request inputs, and it drops each pending bit when the core pulses the matching `interrupt_N_clr`. Software reaches its registers through the data-memory/IO bus in the `0x10xx` IO window.

## Interface
Parameters:
- `BASE_ADDR`, default `8'h20`: low byte of the register block inside the `0x10xx` IO window. Must be 4-aligned.
- `SYNC_STAGES`, default `2`: synchroniser depth per source line. Legal values are 2..3.

Ports:
- `clk`  in  1  the single clock.
- `reset`  in  1  asynchronous, active-low reset.
- `irq_src`  in  4  raw, asynchronous peripheral event lines.
- `dMemIOAddress`  in  16  bus address.
- `dMemIOIn`  in  8  bus write data.
- `dMemIOWriteEn`  in  1  bus write strobe.
- `dMemIOReadEn`  in  1  bus read strobe.
- `rdata`  out  8  registered read data. Reads `0` when the controller is not selected.
- `interrupt_0`..`interrupt_3`  out  1 each  masked request lines to the core.
- `interrupt_0_clr`..`interrupt_3_clr`  in  1 each  one-cycle acknowledge pulses from the core.

## Operation
- Register map, at `{8'h10, BASE_ADDR + off}`:
  - `+0` PEND: read returns the pending bits; writing 1 to a bit clears it (W1C).
  - `+1` MASK: read/write. Bit N=1 enables `interrupt_N`.
  - `+2` EDGE: read/write. Bit N=1 means rising-edge mode; 0 means level mode.
  - `+3` SET: write-only, software trigger. Reads return `0`.
- Bits `[7:4]` of every register read as 0 and ignore writes.
- Each source passes through `SYNC_STAGES` flops, then through one history flop used for edge detection.
- Set condition for pending bit N:
  - Rising-edge mode: synced=1 and history=0.
  - Level mode: synced=1, re-evaluated every cycle.
  - Software: a write to SET with bit N=1.
- Clear condition for pending bit N: `interrupt_N_clr`, or a PEND write with bit N=1.
- Set and clear in the same cycle: set wins, so no event is lost. In level mode the bit therefore re-asserts while the source is held high.
- `interrupt_N = PEND[N] & MASK[N]`, driven combinationally from flops only, so it is glitch-free.
- Masking never discards pending state. Unmasking an already-pending bit asserts `interrupt_N` in the same cycle the MASK write is registered.
- EDGE writes take effect next cycle. Switching a line to rising-edge mode while its source is held high does not set the pending bit.
- Accesses outside the 4-byte block are ignored, and `rdata` is 0 for them.
- Read and write in the same cycle: the write applies and `rdata` returns the pre-write value.

## Timing
- Reset values:
  - PEND=0, MASK=0, EDGE=`4'hF`.
  - Synchroniser and history flops = 0.
  - `rdata`=0, all `interrupt_N`=0.
- Reset asserts asynchronously and releases synchronously to `clk`.
- A source rising before edge k sets PEND at edge k+`SYNC_STAGES`. `interrupt_N` is high immediately after that edge, so latency is 2 edges at the default depth.
- A source pulse must be high for at least one full `clk` period to be captured.
- Clear latency: an `interrupt_N_clr` sampled at edge k gives `interrupt_N`=0 after edge k, unless a set condition is present at that edge.
- Read latency is one cycle: `dMemIOReadEn` at edge k makes `rdata` valid after edge k and held until the next read edge.
- Writes take effect at the edge where `dMemIOWriteEn` is sampled.
- Reset mid-operation: all pending and mask state is lost. Events in flight in the synchroniser are discarded.

## Configuration
- `IRQ_CTRL_SW_TRIGGER_EN` defined: the SET register at `+3` is implemented as described.
- Undefined: writes to `+3` are ignored, `+3` reads 0, and the SET path logic is absent.

## Structure
- Shared package `irq_ctrl_pkg` holds:
  - the register offset constants `PEND_OFF`, `MASK_OFF`, `EDGE_OFF`, `SET_OFF`;
  - the source count `NUM_IRQ=4`;
  - the reset constant `EDGE_RST=4'hF`.
- One sub-module, `irq_sync`: a `SYNC_STAGES` synchroniser plus history flop. It outputs `level` and `rise` per line and is instantiated 4×.

## Test plan
- Rising-edge capture: reset, write MASK=`0x01`, raise `irq_src[0]` for 1 cycle. Expect `interrupt_0`=1 two edges later; pulse `interrupt_0_clr`, expect `interrupt_0`=0 and PEND read = `0x00`.
- Mask retention: MASK=0, pulse `irq_src[2]`. Expect PEND=`0x04` and `interrupt_2`=0. Then write MASK=`0x04` and expect `interrupt_2`=1 after that edge.
- Level mode: write EDGE=`0x0E`, MASK=`0x01`, hold `irq_src[0]` high. Pulse `interrupt_0_clr` and expect `interrupt_0` to stay 1. Drop the source, clear, and expect 0.
- Set/clear collision: PEND[1] already set, a new `irq_src[1]` rise lands in the same cycle as `interrupt_1_clr`. Expect PEND[1] to remain 1.
- W1C and software trigger (with `IRQ_CTRL_SW_TRIGGER_EN`): write SET=`0x0A` and expect PEND=`0x0A`. Write PEND=`0x02` and expect PEND=`0x08`. Without the macro, SET has no effect.
- Async reset: assert `reset`=0 mid-clock with pending bits set. Expect all outputs 0 immediately, and EDGE to read `0x0F` after release.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : irq_ctrl_pkg                                                 |
// | Description : Shared constants and types for the interrupt controller.     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package irq_ctrl_pkg;

  localparam int NUM_IRQ = 4;

  localparam logic [1:0] PEND_OFF = 2'd0;
  localparam logic [1:0] MASK_OFF = 2'd1;
  localparam logic [1:0] EDGE_OFF = 2'd2;
  localparam logic [1:0] SET_OFF  = 2'd3;

  localparam logic [7:0] IO_PAGE = 8'h10;

  typedef logic [NUM_IRQ-1:0] irq_vec_t;

  localparam irq_vec_t EDGE_RST = 4'hF;

  // Registers are NUM_IRQ bits wide; the upper bus bits always read as zero.
  function automatic logic [7:0] pad_reg(input irq_vec_t v);
    return {{(8-NUM_IRQ){1'b0}}, v};
  endfunction

endpackage
`default_nettype wire

// File: rtl/irq_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : irq_sync                                                     |
// | Description : Per-line synchroniser plus history flop; level and rise out. |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic src_i,
  output logic level_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], src_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule
`default_nettype wire

// File: rtl/irq_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : irq_controller                                               |
// | Description : 4-line memory-mapped interrupt controller (PEND/MASK/EDGE).  |
// |               Define IRQ_CTRL_SW_TRIGGER_EN to implement the SET register. |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module irq_controller
  import irq_ctrl_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR   = 8'h20,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  irq_src,
  input  logic [15:0] dMemIOAddress,
  input  logic [7:0]  dMemIOIn,
  input  logic        dMemIOWriteEn,
  input  logic        dMemIOReadEn,
  output logic [7:0]  rdata,
  output logic        interrupt_0,
  output logic        interrupt_1,
  output logic        interrupt_2,
  output logic        interrupt_3,
  input  logic        interrupt_0_clr,
  input  logic        interrupt_1_clr,
  input  logic        interrupt_2_clr,
  input  logic        interrupt_3_clr
);

  irq_vec_t   src_level;
  irq_vec_t   src_rise;
  irq_vec_t   hw_set;
  irq_vec_t   sw_set;
  irq_vec_t   wr_clr;
  irq_vec_t   ack_clr;
  irq_vec_t   wr_data;
  irq_vec_t   pend_d;
  irq_vec_t   pend_q;
  irq_vec_t   mask_q;
  irq_vec_t   edge_q;
  irq_vec_t   irq_out;
  logic       sel;
  logic       wr_en;
  logic [1:0] off;
  logic [7:0] rd_val;
  logic [7:0] rdata_q;
  logic       unused_din;

  generate
    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_sync
      irq_sync #(
        .SYNC_STAGES(SYNC_STAGES)
      ) u_sync (
        .clk_i  (clk),
        .rst_ni (reset),
        .src_i  (irq_src[i]),
        .level_o(src_level[i]),
        .rise_o (src_rise[i])
      );
    end
  endgenerate

  assign sel        = (dMemIOAddress[15:8] == IO_PAGE) && (dMemIOAddress[7:2] == BASE_ADDR[7:2]);
  assign off        = dMemIOAddress[1:0];
  assign wr_en      = dMemIOWriteEn & sel;
  assign wr_data    = dMemIOIn[NUM_IRQ-1:0];
  assign unused_din = ^dMemIOIn[7:NUM_IRQ];

  assign ack_clr = {interrupt_3_clr, interrupt_2_clr, interrupt_1_clr, interrupt_0_clr};
  assign hw_set  = (edge_q & src_rise) | (~edge_q & src_level);
  assign wr_clr  = (wr_en && off == PEND_OFF) ? wr_data : '0;

`ifdef IRQ_CTRL_SW_TRIGGER_EN
  assign sw_set = (wr_en && off == SET_OFF) ? wr_data : '0;
`else
  assign sw_set = '0;
`endif

  // Sets are OR-ed in after clearing so a coincident event is never lost.
  assign pend_d = (pend_q & ~(ack_clr | wr_clr)) | hw_set | sw_set;

  always_comb begin
    rd_val = '0;
    case (off)
      PEND_OFF: rd_val = pad_reg(pend_q);
      MASK_OFF: rd_val = pad_reg(mask_q);
      EDGE_OFF: rd_val = pad_reg(edge_q);
      default:  rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q  <= '0;
      mask_q  <= '0;
      edge_q  <= EDGE_RST;
      rdata_q <= '0;
    end else begin
      pend_q <= pend_d;
      if (wr_en && off == MASK_OFF) mask_q <= wr_data;
      if (wr_en && off == EDGE_OFF) edge_q <= wr_data;
      if (dMemIOReadEn) rdata_q <= sel ? rd_val : '0;
    end
  end

  assign irq_out     = pend_q & mask_q;
  assign interrupt_0 = irq_out[0];
  assign interrupt_1 = irq_out[1];
  assign interrupt_2 = irq_out[2];
  assign interrupt_3 = irq_out[3];
  assign rdata       = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_irq_controller                                            |
// | Description : Randomised self-checking bench with behavioural model.       |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_irq_controller;

  localparam logic [7:0] BASE = 8'h20;
  localparam int         S    = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  irq_src = '0;
  logic [15:0] addr = '0;
  logic [7:0]  din = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [7:0]  rdata;
  logic        int0, int1, int2, int3;
  logic [3:0]  clr = '0;
  logic [3:0]  ints;

  int errors = 0;
  int checks = 0;

  irq_controller #(.BASE_ADDR(BASE), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset), .irq_src(irq_src),
    .dMemIOAddress(addr), .dMemIOIn(din),
    .dMemIOWriteEn(we), .dMemIOReadEn(re), .rdata(rdata),
    .interrupt_0(int0), .interrupt_1(int1), .interrupt_2(int2), .interrupt_3(int3),
    .interrupt_0_clr(clr[0]), .interrupt_1_clr(clr[1]),
    .interrupt_2_clr(clr[2]), .interrupt_3_clr(clr[3])
  );

  always #5 clk = ~clk;
  assign ints = {int3, int2, int1, int0};

  // Behavioural model: a delay line of past source samples plus register values.
  logic [3:0] m_pend = '0, m_mask = '0, m_edge = 4'hF;
  logic [7:0] m_rdata = '0;
  logic [3:0] past[$];

  function automatic logic [3:0] m_reg(input int o);
    case (o)
      0: return m_pend;
      1: return m_mask;
      2: return m_edge;
      default: return 4'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_pend = '0; m_mask = '0; m_edge = 4'hF; m_rdata = '0;
      past.delete();
      for (int i = 0; i <= S; i++) past.push_back(4'h0);
    end else begin
      logic [3:0] synced, hist, hw, sw, wclr;
      int o;
      bit in_win;
      synced = past[S-1];
      hist   = past[S];
      hw     = 4'h0;
      for (int n = 0; n < 4; n++)
        hw[n] = m_edge[n] ? (synced[n] && !hist[n]) : synced[n];
      o      = int'(addr[7:0]) - int'(BASE);
      in_win = (addr[15:8] == 8'h10) && (o >= 0) && (o < 4);
      if (re) m_rdata = in_win ? {4'h0, m_reg(o)} : 8'h00;
      sw = 4'h0; wclr = 4'h0;
      if (we && in_win) begin
        if (o == 0) wclr = din[3:0];
        if (o == 1) m_mask = din[3:0];
        if (o == 2) m_edge = din[3:0];
`ifdef IRQ_CTRL_SW_TRIGGER_EN
        if (o == 3) sw = din[3:0];
`endif
      end
      m_pend = (m_pend & ~(clr | wclr)) | hw | sw;
      past.push_front(irq_src);
      void'(past.pop_back());
    end
    #1;
    checks++;
    if (ints !== (m_pend & m_mask)) begin
      errors++;
      $display("FAIL cyc_interrupts t=%0t got=%h exp=%h", $time, ints, m_pend & m_mask);
    end
    checks++;
    if (rdata !== m_rdata) begin
      errors++;
      $display("FAIL cyc_rdata t=%0t got=%h exp=%h", $time, rdata, m_rdata);
    end
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [1:0] o, input logic [7:0] d);
    addr = {8'h10, BASE + {6'd0, o}}; din = d; we = 1'b1; re = 1'b0;
    cyc(1);
    we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] o, output logic [7:0] d);
    addr = {8'h10, BASE + {6'd0, o}}; we = 1'b0; re = 1'b1;
    cyc(1);
    re = 1'b0;
    d = rdata;
  endtask

  initial begin
    #300000;
    errors++;
    $display("FAIL watchdog timeout at %0t", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    cyc(3);
    reset = 1'b1;
    cyc(1);
    chk("rst_ints", {4'h0, ints}, 8'h00);
    rd(2'd0, d); chk("rst_pend", d, 8'h00);
    rd(2'd1, d); chk("rst_mask", d, 8'h00);
    rd(2'd2, d); chk("rst_edge", d, 8'h0F);

    // Rising-edge capture and acknowledge
    wr(2'd1, 8'h01);
    irq_src[0] = 1'b1; cyc(1); irq_src[0] = 1'b0;
    chk("edge_lat0", {7'd0, int0}, 8'h00);
    cyc(1); chk("edge_lat1", {7'd0, int0}, 8'h00);
    cyc(1); chk("edge_lat2", {7'd0, int0}, 8'h01);
    clr[0] = 1'b1; cyc(1); clr[0] = 1'b0;
    chk("edge_clr", {7'd0, int0}, 8'h00);
    rd(2'd0, d); chk("edge_pend", d, 8'h00);

    // Mask retention
    wr(2'd1, 8'h00);
    irq_src[2] = 1'b1; cyc(1); irq_src[2] = 1'b0; cyc(3);
    chk("mask_int2_off", {7'd0, int2}, 8'h00);
    rd(2'd0, d); chk("mask_pend", d, 8'h04);
    wr(2'd1, 8'h04);
    chk("mask_int2_on", {7'd0, int2}, 8'h01);
    wr(2'd0, 8'h04); wr(2'd1, 8'h00);

    // Level mode
    wr(2'd2, 8'h0E); wr(2'd1, 8'h01);
    irq_src[0] = 1'b1; cyc(3);
    chk("lvl_on", {7'd0, int0}, 8'h01);
    clr[0] = 1'b1; cyc(1); clr[0] = 1'b0;
    chk("lvl_held", {7'd0, int0}, 8'h01);
    irq_src[0] = 1'b0; cyc(3);
    clr[0] = 1'b1; cyc(1); clr[0] = 1'b0;
    chk("lvl_off", {7'd0, int0}, 8'h00);
    wr(2'd2, 8'h0F); wr(2'd1, 8'h00);

    // Set/clear collision
    wr(2'd1, 8'h02);
    irq_src[1] = 1'b1; cyc(1); irq_src[1] = 1'b0; cyc(3);
    chk("col_pre", {7'd0, int1}, 8'h01);
    irq_src[1] = 1'b1; cyc(1); irq_src[1] = 1'b0; cyc(1);
    clr[1] = 1'b1; cyc(1); clr[1] = 1'b0;
    chk("col_int1", {7'd0, int1}, 8'h01);
    rd(2'd0, d); chk("col_pend", d, 8'h02);
    clr[1] = 1'b1; cyc(1); clr[1] = 1'b0;
    chk("col_after", {7'd0, int1}, 8'h00);
    wr(2'd1, 8'h00);

    // Software trigger and W1C
    wr(2'd3, 8'h0A);
`ifdef IRQ_CTRL_SW_TRIGGER_EN
    rd(2'd0, d); chk("sw_set", d, 8'h0A);
    chk("model_sw_set", {4'h0, m_pend}, 8'h0A);
    wr(2'd0, 8'h02);
    rd(2'd0, d); chk("w1c", d, 8'h08);
    wr(2'd0, 8'h08);
`else
    rd(2'd0, d); chk("sw_absent", d, 8'h00);
    chk("model_sw_absent", {4'h0, m_pend}, 8'h00);
`endif
    rd(2'd3, d); chk("set_reads0", d, 8'h00);
    addr = 16'h1124; re = 1'b1; cyc(1); re = 1'b0;
    chk("out_of_block", rdata, 8'h00);

    // Asynchronous reset mid-cycle
    wr(2'd1, 8'h0F);
    irq_src = 4'hF; cyc(1); irq_src = 4'h0; cyc(3);
    chk("pre_rst_ints", {4'h0, ints}, 8'h0F);
    rd(2'd1, d); chk("pre_rst_rdata", d, 8'h0F);
    #3 reset = 1'b0;
    #1 chk("async_ints", {4'h0, ints}, 8'h00);
    chk("async_rdata", rdata, 8'h00);
    cyc(2);
    reset = 1'b1;
    cyc(1);
    rd(2'd2, d); chk("post_rst_edge", d, 8'h0F);
    rd(2'd1, d); chk("post_rst_mask", d, 8'h00);
    rd(2'd0, d); chk("post_rst_pend", d, 8'h00);

    // Randomised traffic, checked every cycle against the model
    for (int c = 0; c < 3000; c++) begin
      int r;
      for (int n = 0; n < 4; n++) begin
        if ($urandom_range(3) == 0) irq_src[n] = ~irq_src[n];
        clr[n] = ($urandom_range(7) == 0);
      end
      r = $urandom_range(9);
      if (r < 6)      addr = {8'h10, BASE + 8'($urandom_range(3))};
      else if (r < 8) addr = {8'h10, 8'($urandom_range(255))};
      else            addr = 16'($urandom_range(65535));
      din = 8'($urandom_range(255));
      we  = ($urandom_range(2) == 0);
      re  = ($urandom_range(1) == 0);
      if (c == 1500) reset = 1'b0;
      if (c == 1503) reset = 1'b1;
      cyc(1);
    end
    we = 1'b0; re = 1'b0; clr = '0; irq_src = '0;
    cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
